// File: rtl/icon_tx_arbiter_pkg.sv
// Shared types and defaults for the interconnect TX channel arbiter.
// The optional abort timer is enabled by defining ICON_ARB_TIMEOUT_EN.
package icon_tx_arbiter_pkg;

    localparam int ICON_ARB_NUM_REQ        = 4;
    localparam int ICON_ARB_TIMEOUT_CYCLES = 15;
    localparam int ICON_ADDR_W             = 8;
    localparam int ICON_DATA_W             = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } enum_icon_arb_state;

    typedef struct packed {
        logic                   valid;
        logic [ICON_ADDR_W-1:0] addr;
        logic [ICON_DATA_W-1:0] data;
    } type_icon_tx_channel;

    typedef struct packed {
        logic success;
    } type_icon_rx_channel;

endpackage

// File: rtl/icon_tx_arbiter_rr_pick_first.sv
// Combinational round-robin picker: first set bit of req at or after start,
// scanning upward and wrapping modulo N.
module icon_tx_arbiter_rr_pick_first #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start) + i) % N;
            if (!found && req[IW'(j)]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/icon_tx_arbiter.sv
// Round-robin arbiter for one shared interconnect TX channel.
// Define ICON_ARB_TIMEOUT_EN to abort a grant that sees no success within TIMEOUT_CYCLES.
module icon_tx_arbiter
    import icon_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = ICON_ARB_NUM_REQ,
    parameter int TIMEOUT_CYCLES = ICON_ARB_TIMEOUT_CYCLES,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  type_icon_tx_channel [NUM_REQ-1:0]  i_req_tx,
    input  logic [NUM_REQ-1:0]                 i_req_opx,
    output type_icon_rx_channel [NUM_REQ-1:0]  o_req_rx,
    output type_icon_tx_channel                o_bus_tx,
    output logic                               o_bus_opx,
    input  type_icon_rx_channel                i_bus_rx,
    output logic [GW-1:0]                      o_grant_idx,
    output logic                               o_busy,
    output logic                               o_timeout
);

    // Handshake: a requester raises valid with a stable payload and holds both
    // until it sees its own o_req_rx.success; the winner's payload is latched at
    // capture, so later requester-side changes never reach the bus.

    enum_icon_arb_state  state_q, state_d;
    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    type_icon_tx_channel bus_tx_q, bus_tx_d;
    logic                bus_opx_q, bus_opx_d;

    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [GW-1:0]       pick_start;
    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic [GW-1:0]       grant_inc;
    logic                ack;
    logic                capture;
    logic                expire;

    always_comb begin
        req_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_valid[k] = i_req_tx[k].valid;
        end
    end

    assign grant_inc = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign ack       = (state_q == ARB_BUSY) && i_bus_rx.success;

    // In BUSY the picker only matters on an ack: it then searches for the
    // back-to-back successor starting after the finishing owner.
    always_comb begin
        pick_mask  = req_valid;
        pick_start = rr_ptr_q;
        if (state_q == ARB_BUSY) begin
            pick_mask[grant_q] = 1'b0;
            pick_start         = grant_inc;
        end
    end

    icon_tx_arbiter_rr_pick_first #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign capture = pick_found && ((state_q == ARB_IDLE) || ack);

`ifdef ICON_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Success on the expiry cycle takes precedence over the abort.
    assign expire = (state_q == ARB_BUSY) && !i_bus_rx.success
                    && (cnt_q == CW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = expire;
        if (capture || expire) begin
            cnt_d = '0;
        end else if ((state_q == ARB_BUSY) && !i_bus_rx.success) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            bus_tx_q  <= '0;
            bus_opx_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            bus_tx_q  <= bus_tx_d;
            bus_opx_q <= bus_opx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                if (ack)         state_d = pick_found ? ARB_BUSY : ARB_IDLE;
                else if (expire) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Holding registers and rotation pointer
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        bus_tx_d  = bus_tx_q;
        bus_opx_d = bus_opx_q;
        if (ack || expire) begin
            rr_ptr_d       = grant_inc;
            bus_tx_d.valid = 1'b0;
        end
        if (capture) begin
            grant_d        = pick_idx;
            bus_tx_d       = i_req_tx[pick_idx];
            bus_tx_d.valid = 1'b1;
            bus_opx_d      = i_req_opx[pick_idx];
        end
    end

    // Outputs
    always_comb begin
        o_busy = (state_q == ARB_BUSY);
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_rx[k].success = ack && (grant_q == GW'(k));
        end
    end

    assign o_bus_tx    = bus_tx_q;
    assign o_bus_opx   = bus_opx_q;
    assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_icon_tx_arbiter.sv
// Directed bench for icon_tx_arbiter: vector table plus hand-written corner sequences.
module tb_icon_tx_arbiter;
  import icon_tx_arbiter_pkg::*;

  localparam int W = 34;

  logic                                      clk;
  logic                                      rst;
  type_icon_tx_channel [ICON_ARB_NUM_REQ-1:0] req_tx;
  logic [ICON_ARB_NUM_REQ-1:0]               req_opx;
  type_icon_rx_channel [ICON_ARB_NUM_REQ-1:0] req_rx;
  type_icon_tx_channel                       bus_tx;
  logic                                      bus_opx;
  type_icon_rx_channel                       bus_rx;
  logic [1:0]                                grant_idx;
  logic                                      busy;
  logic                                      timeout;

  icon_tx_arbiter dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_tx    (req_tx),
    .i_req_opx   (req_opx),
    .o_req_rx    (req_rx),
    .o_bus_tx    (bus_tx),
    .o_bus_opx   (bus_opx),
    .i_bus_rx    (bus_rx),
    .o_grant_idx (grant_idx),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic       succ;
    logic       busy;
    logic [1:0] grant;
    logic [3:0] rx;
  } vec_t;

  vec_t        tbl [19];
  logic [15:0] data_c [4];
  logic [3:0]  opx_c;
  logic [3:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  function automatic logic [3:0] rx_bits();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = req_rx[k].success;
    return r;
  endfunction

  function automatic logic [W-1:0] act_raw();
    return {busy, bus_tx.valid, grant_idx, rx_bits(), bus_opx,
            bus_tx.data, bus_tx.addr, timeout};
  endfunction

  function automatic logic [W-1:0] act_masked();
    if (busy)
      return act_raw();
    return {1'b0, bus_tx.valid, 2'b00, rx_bits(), 1'b0, 16'h0, 8'h0, timeout};
  endfunction

  function automatic logic [W-1:0] make_exp(logic b, logic [1:0] g, logic [3:0] rx, logic tmo);
    if (b)
      return {1'b1, 1'b1, g, rx, opx_c[g], data_c[g], 8'h20 + {6'd0, g}, tmo};
    return {1'b0, 1'b0, 2'b00, rx, 1'b0, 16'h0, 8'h0, tmo};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] vld, input logic succ);
    for (int k = 0; k < 4; k++) req_tx[k].valid = vld[k];
    bus_rx.success = succ;
  endtask

  task automatic step(input logic [3:0] vld, input logic succ, input logic b,
                      input logic [1:0] g, input logic [3:0] rx, input logic tmo,
                      input string name);
    @(negedge clk);
    drive(vld, succ);
    #1;
    check(name, act_masked(), make_exp(b, g, rx, tmo));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    data_c = '{16'h1100, 16'h2211, 16'h00A5, 16'h4433};
    opx_c  = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      req_tx[k].addr = 8'h20 + 8'(k);
      req_tx[k].data = data_c[k];
    end
    req_opx = opx_c;

    //            vld      succ  busy grant rx
    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[3]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[6]  = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[7]  = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[8]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[9]  = '{4'b1011, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[10] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    tbl[11] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[12] = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[13] = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[14] = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001};
    tbl[15] = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[16] = '{4'b1101, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[17] = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000};
    tbl[18] = '{4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000};

    // expected ack order across the table
    exp_q = '{4'd2, 4'd1, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};

    rst = 1'b1;
    drive(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", act_raw(), '0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].succ);
      #1;
      check($sformatf("row%0d", i), act_masked(),
            make_exp(tbl[i].busy, tbl[i].grant, tbl[i].rx, 1'b0));
      if (rx_bits() != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check($sformatf("ack_unexpected_row%0d", i), {30'd0, rx_bits()}, '0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check($sformatf("ack_order_row%0d", i), {30'd0, rx_bits()},
                {30'd0, 4'b0001 << e});
        end
      end
    end
    check("ack_queue_empty", W'(exp_q.size()), '0);

    // reset while requester 0 owns the bus
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0001, 1'b0);
    @(negedge clk);
    #1;
    check("reset_mid_busy", act_raw(), '0);
    rst = 1'b0;
    step(4'b0001, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, "regrant_after_reset");
    step(4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, "ack_after_reset");
    step(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, "idle_after_reset_ack");

`ifdef ICON_ARB_TIMEOUT_EN
    step(4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, "tmo_capture");
    for (int i = 0; i < 16; i++)
      step(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, $sformatf("tmo_wait%0d", i));
    step(4'b0011, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, "tmo_abort_pulse");
    step(4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, "tmo_rr_after_abort");
    for (int i = 0; i < 15; i++)
      step(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, $sformatf("tmo_regrant_wait%0d", i));
    step(4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, "tmo_success_on_expiry");
    step(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, "tmo_no_pulse_after_success");
`else
    step(4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, "hold_capture");
    for (int i = 0; i < 20; i++)
      step(4'b0010, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, $sformatf("hold_wait%0d", i));
    step(4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, "hold_late_ack");
    step(4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, "hold_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
